count_seq_monitor: RTL

COUNT_SEQ_MONITOR -- requirements
Module: count_seq_monitor

---
 rtl/count_seq_monitor_if.sv | 26 ++
 rtl/count_seq_monitor.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/count_seq_monitor_if.sv
// Bundle between a mod-6 counter source and the sequence monitor.
// The master drives samples and clear; the slave (monitor) returns status and display.
interface count_seq_monitor_if #(
  parameter int unsigned ROLL_W = 8
);
  logic [2:0]        count_in;
  logic              count_vld;
  logic              clear;
  logic              locked;
  logic              fault;
  logic              rollover_pulse;
  logic [ROLL_W-1:0] rollover_cnt;
  logic              roll_ovf;
  logic [3:0]        err_cnt;
  logic [6:0]        seg;

  modport master (
    output count_in, count_vld, clear,
    input  locked, fault, rollover_pulse, rollover_cnt, roll_ovf, err_cnt, seg
  );

  modport slave (
    input  count_in, count_vld, clear,
    output locked, fault, rollover_pulse, rollover_cnt, roll_ovf, err_cnt, seg
  );
endinterface

// File: rtl/count_seq_monitor.sv
// Checks that an upstream mod-6 counter steps 0..5 in order, counts wraps and
// errors, and latches into FAULT after ERR_LIMIT consecutive sequence errors.
module count_seq_monitor #(
  parameter int unsigned ROLL_W    = 8,
  parameter int unsigned ERR_LIMIT = 3
) (
  input logic                clk,
  input logic                rst,
  count_seq_monitor_if.slave bus
);

  typedef enum logic [1:0] {SYNC = 2'd0, LOCKED = 2'd1, FAULT = 2'd2} state_t;

  state_t            state_q, state_d;
  logic [2:0]        last_q, last_d;
  logic [3:0]        consec_q, consec_d;
  logic [3:0]        err_q, err_d;
  logic [ROLL_W-1:0] roll_q, roll_d;
  logic              ovf_q, ovf_d;
  logic              pulse_q, pulse_d;
  logic              locked_q, locked_d;
  logic              fault_q, fault_d;
  logic [6:0]        seg_q, seg_d;
  logic              in_range_s;
  logic              good_step_s;

  function automatic logic [3:0] sat_inc(input logic [3:0] v);
    return (v == 4'hF) ? v : v + 4'd1;
  endfunction

  function automatic logic [6:0] seg_of(input logic [2:0] v);
    case (v)
      3'd0:    return 7'h3F;
      3'd1:    return 7'h06;
      3'd2:    return 7'h5B;
      3'd3:    return 7'h4F;
      3'd4:    return 7'h66;
      3'd5:    return 7'h6D;
      default: return 7'h00;
    endcase
  endfunction

  assign in_range_s  = (bus.count_in <= 3'd5);
  // last_q never exceeds 5 while LOCKED, so 5 is the only wrap source
  assign good_step_s = (last_q == 3'd5) ? (bus.count_in == 3'd0)
                                        : (bus.count_in == last_q + 3'd1);

  // Next-state and next-output evaluation for one sample cycle
  always_comb begin
    state_d  = state_q;
    last_d   = last_q;
    consec_d = consec_q;
    err_d    = err_q;
    roll_d   = roll_q;
    ovf_d    = ovf_q;
    pulse_d  = 1'b0;
    if (bus.clear) begin
      state_d  = SYNC;
      err_d    = 4'd0;
      consec_d = 4'd0;
    end else if (bus.count_vld) begin
      case (state_q)
        SYNC: begin
          if (in_range_s) begin
            last_d  = bus.count_in;
            state_d = LOCKED;
          end else begin
            err_d = sat_inc(err_q);
          end
        end
        LOCKED: begin
          if (bus.count_in == last_q) begin
            consec_d = 4'd0;
          end else if (good_step_s) begin
            last_d   = bus.count_in;
            consec_d = 4'd0;
            if (bus.count_in == 3'd0) begin
              pulse_d = 1'b1;
              roll_d  = roll_q + ROLL_W'(1);
              ovf_d   = ovf_q | (roll_q == '1);
            end else begin
              pulse_d = 1'b0;
            end
          end else begin
            err_d    = sat_inc(err_q);
            consec_d = sat_inc(consec_q);
            if (in_range_s) begin
              last_d = bus.count_in;
            end else begin
              last_d = last_q;
            end
            if (consec_d >= 4'(ERR_LIMIT)) begin
              state_d = FAULT;
            end else begin
              state_d = LOCKED;
            end
          end
        end
        FAULT:   state_d = FAULT;
        default: state_d = SYNC;
      endcase
    end else begin
      pulse_d = 1'b0;
    end

    locked_d = (state_d == LOCKED);
    fault_d  = (state_d == FAULT);
    case (state_d)
      SYNC:    seg_d = 7'h00;
      LOCKED:  seg_d = seg_of(last_d);
      FAULT:   seg_d = 7'h79;
      default: seg_d = 7'h00;
    endcase
  end

  // State and registered outputs, synchronous reset wins over everything
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= SYNC;
      last_q   <= 3'd0;
      consec_q <= 4'd0;
      err_q    <= 4'd0;
      roll_q   <= '0;
      ovf_q    <= 1'b0;
      pulse_q  <= 1'b0;
      locked_q <= 1'b0;
      fault_q  <= 1'b0;
      seg_q    <= 7'h00;
    end else begin
      state_q  <= state_d;
      last_q   <= last_d;
      consec_q <= consec_d;
      err_q    <= err_d;
      roll_q   <= roll_d;
      ovf_q    <= ovf_d;
      pulse_q  <= pulse_d;
      locked_q <= locked_d;
      fault_q  <= fault_d;
      seg_q    <= seg_d;
    end
  end

  assign bus.locked         = locked_q;
  assign bus.fault          = fault_q;
  assign bus.rollover_pulse = pulse_q;
  assign bus.rollover_cnt   = roll_q;
  assign bus.roll_ovf       = ovf_q;
  assign bus.err_cnt        = err_q;
  assign bus.seg            = seg_q;

endmodule
